// File: rtl/if_stage_ctrl.sv
// Fetch-stage controller: owns the PC, the single-outstanding imem handshake and the IF/ID register.
// Optional IF_PERF_CNT_EN adds saturating stall/flush cycle counters.
module if_stage_ctrl #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_stall,
    input  logic            flush,
    input  logic [XLEN-1:0] br_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_instr
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic [31:0]     skid_instr_q, skid_instr_d;
    logic            if_id_valid_q, if_id_valid_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
    logic [31:0]     if_id_instr_q, if_id_instr_d;

    logic            xfer;
    logic [XLEN-1:0] tgt_aligned;
    logic [XLEN-1:0] pc_inc;

    // Low two target bits are masked rather than sliced so the whole bus is consumed.
    assign tgt_aligned = br_target & ~XLEN'(3);
    assign pc_inc      = pc_q + XLEN'(4);

    assign imem_req    = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign imem_addr   = pc_q;
    assign xfer        = imem_req & imem_ready;

    assign if_id_valid = if_id_valid_q;
    assign if_id_pc    = if_id_valid_q ? if_id_pc_q : {XLEN{1'b0}};
    assign if_id_instr = if_id_valid_q ? if_id_instr_q : NOP;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redir_pc_d    = redir_pc_q;
        skid_valid_d  = skid_valid_q;
        skid_pc_d     = skid_pc_q;
        skid_instr_d  = skid_instr_q;
        if_id_valid_d = if_id_valid_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;

        unique case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
                if (flush) pc_d = tgt_aligned;
            end
            S_FETCH: begin
                if (flush) begin
                    if_id_valid_d = 1'b0;
                    if (xfer) begin
                        pc_d = tgt_aligned;
                    end else begin
                        // Request already raised: it must complete before redirecting.
                        redir_pc_d = tgt_aligned;
                        state_d    = S_DRAIN;
                    end
                end else if (load_stall) begin
                    if (xfer) begin
                        skid_valid_d = 1'b1;
                        skid_pc_d    = pc_q;
                        skid_instr_d = imem_rdata;
                        pc_d         = pc_inc;
                        state_d      = S_HOLD;
                    end
                end else if (xfer) begin
                    if_id_valid_d = 1'b1;
                    if_id_pc_d    = pc_q;
                    if_id_instr_d = imem_rdata;
                    pc_d          = pc_inc;
                end else begin
                    // Decode consumed IF/ID; nothing arrived to replace it.
                    if_id_valid_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    skid_valid_d  = 1'b0;
                    if_id_valid_d = 1'b0;
                    pc_d          = tgt_aligned;
                    state_d       = S_FETCH;
                end else if (!load_stall) begin
                    if_id_valid_d = skid_valid_q;
                    if_id_pc_d    = skid_pc_q;
                    if_id_instr_d = skid_instr_q;
                    skid_valid_d  = 1'b0;
                    state_d       = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (flush) if_id_valid_d = 1'b0;
                if (xfer) begin
                    pc_d    = flush ? tgt_aligned : redir_pc_q;
                    state_d = S_FETCH;
                end else if (flush) begin
                    redir_pc_d = tgt_aligned;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            redir_pc_q    <= RESET_PC;
            skid_valid_q  <= 1'b0;
            skid_pc_q     <= {XLEN{1'b0}};
            skid_instr_q  <= NOP;
            if_id_valid_q <= 1'b0;
            if_id_pc_q    <= {XLEN{1'b0}};
            if_id_instr_q <= NOP;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redir_pc_q    <= redir_pc_d;
            skid_valid_q  <= skid_valid_d;
            skid_pc_q     <= skid_pc_d;
            skid_instr_q  <= skid_instr_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (load_stall && !flush && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush && (flush_cnt_q != 32'hFFFF_FFFF))
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Self-checking bench for if_stage_ctrl: directed scenarios plus randomized traffic against a transaction-level model.
module tb_if_stage_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        load_stall;
    logic        flush;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    assign imem_rdata = rom(imem_addr);

    if_stage_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_stall  (load_stall),
        .flush       (flush),
        .br_target   (br_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr)
`ifdef IF_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish within time budget");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        load_stall = 1'b0;
        flush      = 1'b0;
        br_target  = 32'h0;
        imem_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst        = 1'b0;
        load_stall = 1'b0;
        flush      = 1'b0;
        br_target  = 32'h0;
        imem_ready = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || if_id_valid !== 1'b0 ||
            if_id_pc !== 32'h0 || if_id_instr !== NOP) begin
            errors++;
            $display("FAIL reset_async: req=%b addr=%h v=%b pc=%h instr=%h, required 0 0 0 0 %h",
                     imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instr, NOP);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL boot_no_req: imem_req=%b required 0", imem_req);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL edge1: req=%b addr=%h v=%b, required 1 00000000 0", imem_req, imem_addr, if_id_valid);
        end
        tick();
        checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || if_id_instr !== rom(32'h0) || imem_addr !== 32'h4) begin
            errors++;
            $display("FAIL edge2: v=%b pc=%h instr=%h addr=%h, required 1 00000000 %h 00000004",
                     if_id_valid, if_id_pc, if_id_instr, imem_addr, rom(32'h0));
        end
        $display("test_reset done");
    endtask

    task automatic test_stream;
        do_reset();
        tick();
        tick();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (if_id_valid !== 1'b1 || if_id_pc !== 32'(4 * k) || if_id_instr !== rom(32'(4 * k)) ||
                imem_addr !== 32'(4 * k + 4)) begin
                errors++;
                $display("FAIL stream[%0d]: v=%b pc=%h instr=%h addr=%h, required pc=%h addr=%h",
                         k, if_id_valid, if_id_pc, if_id_instr, imem_addr, 32'(4 * k), 32'(4 * k + 4));
            end
            tick();
        end
        $display("test_stream done");
    endtask

    task automatic test_stall_skid;
        do_reset();
        repeat (5) tick();
        load_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0C || if_id_instr !== rom(32'h0C) || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: v=%b pc=%h req=%b, required 1 0000000c 0",
                         k, if_id_valid, if_id_pc, imem_req);
            end
        end
        load_stall = 1'b0;
        tick();
        checks++;
        if (if_id_pc !== 32'h10 || if_id_instr !== rom(32'h10) || imem_req !== 1'b1 || imem_addr !== 32'h14) begin
            errors++;
            $display("FAIL skid_release: pc=%h instr=%h req=%b addr=%h, required 00000010 %h 1 00000014",
                     if_id_pc, if_id_instr, imem_req, imem_addr, rom(32'h10));
        end
        tick();
        checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h14) begin
            errors++;
            $display("FAIL after_skid: v=%b pc=%h, required 1 00000014", if_id_valid, if_id_pc);
        end
        $display("test_stall_skid done");
    endtask

    task automatic test_flush_fetch;
        do_reset();
        repeat (3) tick();
        flush     = 1'b1;
        br_target = 32'h200;
        tick();
        flush = 1'b0;
        checks++;
        if (if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc !== 32'h0 || imem_addr !== 32'h200) begin
            errors++;
            $display("FAIL flush_fetch: v=%b instr=%h pc=%h addr=%h, required 0 %h 0 00000200",
                     if_id_valid, if_id_instr, if_id_pc, imem_addr, NOP);
        end
        tick();
        checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h200 || if_id_instr !== rom(32'h200)) begin
            errors++;
            $display("FAIL flush_target: v=%b pc=%h instr=%h, required 1 00000200 %h",
                     if_id_valid, if_id_pc, if_id_instr, rom(32'h200));
        end
        $display("test_flush_fetch done");
    endtask

    task automatic test_flush_drain;
        do_reset();
        repeat (9) tick();
        imem_ready = 1'b0;
        flush      = 1'b1;
        br_target  = 32'h300;
        for (int k = 0; k < 4; k++) begin
            tick();
            flush = 1'b0;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h20 || if_id_valid !== 1'b0) begin
                errors++;
                $display("FAIL drain_hold[%0d]: req=%b addr=%h v=%b, required 1 00000020 0",
                         k, imem_req, imem_addr, if_id_valid);
            end
        end
        imem_ready = 1'b1;
        tick();
        checks++;
        if (if_id_valid !== 1'b0 || imem_addr !== 32'h300) begin
            errors++;
            $display("FAIL drain_done: v=%b addr=%h, required 0 00000300", if_id_valid, imem_addr);
        end
        tick();
        checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h300) begin
            errors++;
            $display("FAIL drain_target: v=%b pc=%h, required 1 00000300", if_id_valid, if_id_pc);
        end
        $display("test_flush_drain done");
    endtask

    task automatic test_flush_and_stall;
        do_reset();
        repeat (5) tick();
        load_stall = 1'b1;
        tick();
        flush     = 1'b1;
        br_target = 32'h103;
        tick();
        checks++;
        if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL flush_stall_hold: v=%b req=%b addr=%h, required 0 1 00000100",
                     if_id_valid, imem_req, imem_addr);
        end
        flush      = 1'b0;
        load_stall = 1'b0;
        tick();
        checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h100 || if_id_instr !== rom(32'h100) || imem_addr !== 32'h104) begin
            errors++;
            $display("FAIL flush_stall_next: v=%b pc=%h addr=%h, required 1 00000100 00000104",
                     if_id_valid, if_id_pc, imem_addr);
        end
        flush      = 1'b1;
        load_stall = 1'b1;
        tick();
        flush      = 1'b0;
        load_stall = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 || if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall_fetch: req=%b addr=%h v=%b, required 1 00000100 0",
                     imem_req, imem_addr, if_id_valid);
        end
        $display("test_flush_and_stall done");
    endtask

    task automatic test_async_reset_drain;
        do_reset();
        repeat (3) tick();
        imem_ready = 1'b0;
        flush      = 1'b1;
        br_target  = 32'h40;
        tick();
        flush = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            errors++;
            $display("FAIL pre_reset_drain: req=%b addr=%h, required 1 00000008", imem_req, imem_addr);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || if_id_valid !== 1'b0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_drain: req=%b v=%b addr=%h, required 0 0 00000000",
                     imem_req, if_id_valid, imem_addr);
        end
        @(posedge clk);
        #1;
        rst        = 1'b0;
        imem_ready = 1'b1;
        $display("test_async_reset_drain done");
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetched_t;

    task automatic test_random;
        fetched_t    skid[$];
        fetched_t    ent;
        bit          m_boot, m_discard, m_ifv;
        logic [31:0] m_pc, m_redir, m_ifpc, m_ifin;
        logic [31:0] e_pc, e_instr, aligned;
        bit          e_req, st, fl, rd;
        logic [31:0] tg;
        int          cyc_err;
`ifdef IF_PERF_CNT_EN
        logic [31:0] m_scnt, m_fcnt;
        m_scnt = 0;
        m_fcnt = 0;
`endif
        do_reset();
        m_boot    = 1;
        m_discard = 0;
        m_ifv     = 0;
        m_pc      = 32'h0;
        m_redir   = 32'h0;
        m_ifpc    = 32'h0;
        m_ifin    = NOP;
        cyc_err   = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            e_req   = !m_boot && (skid.size() == 0);
            e_pc    = m_ifv ? m_ifpc : 32'h0;
            e_instr = m_ifv ? m_ifin : NOP;
            checks++;
            if (imem_req !== e_req || imem_addr !== m_pc || if_id_valid !== m_ifv ||
                if_id_pc !== e_pc || if_id_instr !== e_instr) begin
                errors++;
                cyc_err++;
                if (cyc_err <= 10)
                    $display("FAIL random cyc=%0d: got req=%b addr=%h v=%b pc=%h instr=%h, required req=%b addr=%h v=%b pc=%h instr=%h",
                             cyc, imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instr,
                             e_req, m_pc, m_ifv, e_pc, e_instr);
            end
`ifdef IF_PERF_CNT_EN
            checks++;
            if (stall_cnt !== m_scnt || flush_cnt !== m_fcnt) begin
                errors++;
                $display("FAIL perf cyc=%0d: stall_cnt=%0d flush_cnt=%0d, required %0d %0d",
                         cyc, stall_cnt, flush_cnt, m_scnt, m_fcnt);
            end
`endif
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 9) == 0);
            rd = ($urandom_range(0, 9) < 7);
            tg = $urandom;
            load_stall = st;
            flush      = fl;
            imem_ready = rd;
            br_target  = tg;
            aligned    = {tg[31:2], 2'b00};
`ifdef IF_PERF_CNT_EN
            if (st && !fl) m_scnt++;
            if (fl) m_fcnt++;
`endif
            if (m_boot) begin
                m_boot = 0;
                if (fl) m_pc = aligned;
            end else if (skid.size() > 0) begin
                if (fl) begin
                    skid.delete();
                    m_ifv = 0;
                    m_pc  = aligned;
                end else if (!st) begin
                    ent    = skid.pop_front();
                    m_ifv  = 1;
                    m_ifpc = ent.pc;
                    m_ifin = ent.instr;
                end
            end else if (m_discard) begin
                if (rd) begin
                    m_pc      = fl ? aligned : m_redir;
                    m_discard = 0;
                end else if (fl) begin
                    m_redir = aligned;
                end
            end else if (fl) begin
                m_ifv = 0;
                if (rd) m_pc = aligned;
                else begin
                    m_discard = 1;
                    m_redir   = aligned;
                end
            end else if (st) begin
                if (rd) begin
                    ent.pc    = m_pc;
                    ent.instr = rom(m_pc);
                    skid.push_back(ent);
                    m_pc = m_pc + 32'd4;
                end
            end else if (rd) begin
                m_ifv  = 1;
                m_ifpc = m_pc;
                m_ifin = rom(m_pc);
                m_pc   = m_pc + 32'd4;
            end else begin
                m_ifv = 0;
            end
            tick();
        end
        load_stall = 1'b0;
        flush      = 1'b0;
        imem_ready = 1'b1;
        $display("test_random done: %0d cycle mismatches", cyc_err);
    endtask

    initial begin
        rst        = 1'b1;
        load_stall = 1'b0;
        flush      = 1'b0;
        br_target  = 32'h0;
        imem_ready = 1'b1;
        test_reset();
        test_stream();
        test_stall_skid();
        test_flush_fetch();
        test_flush_drain();
        test_flush_and_stall();
        test_async_reset_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage_ctrl.md
Name: if_stage_ctrl

Overview:
- Fetch-side consumer of the hazard unit's `load_stall` / `flush` outputs. It owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register.
- It freezes IF/ID on a load-use stall and redirects the PC on a branch flush.
- It also guarantees that an instruction already in flight from imem is never lost (stall) and never wrongly issued (flush).
- Sits between imem and the ID stage; drives `if_id_*` into decode.

Parameters:
- XLEN, 32, width of PC and branch target.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- load_stall  input  1  from hazard_detection; hold PC and IF/ID this cycle.
- flush  input  1  from hazard_detection (br_ctrl); kill IF/ID, redirect PC.
- br_target  input  XLEN  redirect address, sampled when flush=1.
- imem_req  output  1  fetch request valid.
- imem_addr  output  XLEN  fetch address; stable while imem_req=1 and imem_ready=0.
- imem_ready  input  1  request accepted; imem_rdata valid in the same cycle.
- imem_rdata  input  32  fetched instruction.
- if_id_valid  output  1  IF/ID holds a live instruction.
- if_id_pc  output  XLEN  PC of the IF/ID instruction.
- if_id_instr  output  32  IF/ID instruction; 32'h0000_0013 (NOP) when invalid.

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC, state=BOOT, skid_valid=0.
  - if_id_valid=0, if_id_pc=0, if_id_instr=NOP.
  - imem_req=0, imem_addr=RESET_PC.
- Handshake: single outstanding request.
  - imem_req=1 with imem_addr=pc in FETCH and DRAIN.
  - A transfer completes on any edge with imem_req & imem_ready.
  - Once raised, imem_req and imem_addr must not change until that transfer completes, whatever the stall/flush inputs.
- States:
  - BOOT: imem_req=0. Next state is FETCH unconditionally, including when flush=1 (flush sets pc=br_target).
  - FETCH, transfer completes, no stall, no flush: IF/ID <= {1, pc, imem_rdata}; pc <= pc+4; stay in FETCH.
  - FETCH, transfer completes, load_stall=1: IF/ID held; skid <= {pc, imem_rdata}; skid_valid=1; pc <= pc+4; go to HOLD.
  - FETCH, no transfer, load_stall=1: IF/ID held; request stays up.
  - HOLD: imem_req=0, IF/ID held while load_stall=1. When load_stall=0: IF/ID <= skid; skid_valid=0; go to FETCH.
  - FETCH, flush=1 and transfer completes: response discarded; if_id_valid=0; pc <= {br_target[XLEN-1:2],2'b00}; stay in FETCH.
  - FETCH, flush=1 and no transfer: if_id_valid=0; redir_pc <= aligned br_target; go to DRAIN.
  - DRAIN: keep the old request until it completes. Discard the response, set pc=redir_pc, go to FETCH.
  - flush in DRAIN: overwrite redir_pc (latest flush wins).
  - flush in HOLD: skid_valid=0; if_id_valid=0; pc=aligned br_target; go to FETCH.
- Priority: flush > load_stall > normal advance. Simultaneous flush and load_stall is handled as flush only.
- Invalid IF/ID: if_id_valid=0 forces if_id_instr=NOP and if_id_pc=0.
- Arithmetic and alignment:
  - pc+4 wraps modulo 2^XLEN; no overflow flag.
  - br_target[1:0] is ignored.
- Timing:
  - Zero-wait imem (imem_ready tied 1): first if_id_valid=1 on the 2nd rising edge after rst deasserts; one instruction per cycle after that.
  - Flush penalty: 1 bubble in FETCH; 1 + remaining wait cycles in DRAIN.
- Reset mid-transfer: the request is abandoned and imem_req drops immediately. imem must tolerate a request dropped by reset.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- When defined, two extra outputs, both reset to 0 and saturating at all-ones:
  - stall_cnt (32 bits): +1 per cycle with load_stall=1 and flush=0.
  - flush_cnt (32 bits): +1 per cycle with flush=1.
- When undefined, neither port nor counter logic exists and behaviour is otherwise identical.

Test Plan:
- Reset release, imem_ready=1, rdata=addr-indexed ROM → imem_addr 0,4,8,... ; if_id_pc 0 on edge 2, then 4, 8 each cycle.
- load_stall=1 for 3 cycles, response for pc=0x10 arriving in the first stall cycle → IF/ID held at 0x0C for 3 cycles, then 0x10 (from skid), then 0x14 with no refetch of 0x10.
- flush=1, br_target=0x200, imem_ready=1 → next if_id_valid=0, next imem_addr=0x200, if_id_pc=0x200 one cycle later.
- imem_ready low 4 cycles with req at 0x20, flush=1 (target 0x300) in cycle 1 → imem_addr stays 0x20 until accepted; 0x20 data never valid in IF/ID; then fetch 0x300.
- flush and load_stall both 1, br_target=0x103 → flush wins; pc=0x100; skid cleared; stall ignored.
- rst pulse asserted mid-DRAIN → imem_req=0, if_id_valid=0 and pc=RESET_PC immediately, without waiting for a clock edge.
